alu_arbiter: RTL and testbench

Shares a single registered 64-bit ALU (AND/OR/XOR/NOR/ADD/SUB) between two requesters, e.g. the EX-stage issue port and a secondary port such as a forwarding or debug unit. Accepts one operation at a time through a valid/ready handshake, arbitrates round-robin when both ports request, computes in one cycle, and returns a tagged result that is held under response backpressure.

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one registered 64-bit ALU through valid/ready.
// Round-robin arbitration on contention, one-cycle execute, tagged response held
// under backpressure. Define ALU_ARB_FLAGS_EN to add the rsp_zero/rsp_carry flags.
module alu_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic             rsp_zero,
  output logic             rsp_carry
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;

  // Adder is one bit wider only when the carry flag is kept.
`ifdef ALU_ARB_FLAGS_EN
  localparam int unsigned SumW = WIDTH + 1;
`else
  localparam int unsigned SumW = WIDTH;
`endif

  logic [1:0]       state_q, state_d;
  logic             armed_q;
  logic             last_grant_q;
  logic             id_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             grant0, grant1, accept;
  logic [SumW-1:0]  sum;
  logic [WIDTH-1:0] alu_data;
  logic             alu_err;

  // Lone requester wins; on contention the port that did not win last time wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  // armed_q keeps both ready lines low while rst_n is asserted.
  assign req0_ready = armed_q && (state_q == IDLE) && grant0;
  assign req1_ready = armed_q && (state_q == IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;
  assign rsp_valid  = (state_q == RESP);

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, arbitration history and capture of the accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      armed_q      <= 1'b0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (accept) begin
        last_grant_q <= req1_ready;
        id_q         <= req1_ready;
        op_q         <= req1_ready ? req1_op : req0_op;
        a_q          <= req1_ready ? req1_a : req0_a;
        b_q          <= req1_ready ? req1_b : req0_b;
      end
    end
  end

  // ALU datapath; SUB runs as a + ~b + 1 so the adder carry is the no-borrow bit.
  always_comb begin
    sum      = '0;
    alu_data = '0;
    alu_err  = 1'b0;
    case (op_q)
      OP_AND: alu_data = a_q & b_q;
      OP_OR:  alu_data = a_q | b_q;
      OP_XOR: alu_data = a_q ^ b_q;
      OP_NOR: alu_data = ~(a_q | b_q);
      OP_ADD: begin
        sum      = SumW'(a_q) + SumW'(b_q);
        alu_data = sum[WIDTH-1:0];
      end
      OP_SUB: begin
        sum      = SumW'(a_q) + SumW'(~b_q) + SumW'(1);
        alu_data = sum[WIDTH-1:0];
      end
      default: alu_err = 1'b1;
    endcase
  end

  // Response registers load once in EXEC and hold through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_id   <= id_q;
      rsp_data <= alu_data;
      rsp_err  <= alu_err;
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  // Flags are registered alongside the result; carry is 0 for non-arithmetic ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_zero  <= (alu_data == '0);
      rsp_carry <= sum[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a per-cycle reference model checks every
// cycle, while directed tables/sequences and random traffic drive the ports.
module tb_alu_arbiter;

  localparam int unsigned W = 64;
  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_XOR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3, OP_SUB = 3'd4, OP_NOR = 3'd5;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;
  logic         rsp_zero, rsp_carry;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef ALU_ARB_FLAGS_EN
    , .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
`endif
  );

`ifndef ALU_ARB_FLAGS_EN
  assign rsp_zero  = 1'b0;
  assign rsp_carry = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference from the operation definitions.
  function automatic void alu_ref(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output bit err, output bit z,
                                  output bit c);
    err = 1'b0;
    c   = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  begin r = a + b; c = (r < a); end
      OP_SUB:  begin r = a - b; c = (a >= b); end
      default: begin r = '0; err = 1'b1; end
    endcase
    z = (r == 64'd0);
  endfunction

  typedef struct { bit id; logic [63:0] data; bit err; bit zero; bit carry; } rsp_t;
  rsp_t rsp_log[$];

  // Model state: outstanding operation, edges since accept, last winner.
  bit          m_out, m_last, m_armed, d_armed, d_acc, d_port, d_hs;
  int          m_age;
  logic [2:0]  d_op;
  logic [63:0] d_a, d_b, e_data;
  bit          e_id, e_err, e_zero, e_carry;
  rsp_t        d_rsp;

  // Per-cycle checker, 3 time units after the falling edge (inputs settled).
  always @(negedge clk) begin
    bit x0, x1, xv;
    #3;
    if (!rst_n) begin
      m_out = 1'b0; m_age = 0; m_last = 1'b1; m_armed = 1'b0; d_armed = 1'b0;
      d_acc = 1'b0; d_hs = 1'b0;
      chk1("rst_req0_ready", req0_ready, 1'b0);
      chk1("rst_req1_ready", req1_ready, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk1("rst_rsp_id", rsp_id, 1'b0);
      chk1("rst_rsp_err", rsp_err, 1'b0);
      chk64("rst_rsp_data", rsp_data, 64'd0);
`ifdef ALU_ARB_FLAGS_EN
      chk1("rst_rsp_zero", rsp_zero, 1'b0);
      chk1("rst_rsp_carry", rsp_carry, 1'b0);
`endif
    end else begin
      m_armed = d_armed;
      d_armed = 1'b1;
      if (d_hs) begin
        m_out = 1'b0;
        rsp_log.push_back(d_rsp);
      end else if (d_acc) begin
        m_out  = 1'b1;
        m_age  = 0;
        m_last = d_port;
        e_id   = d_port;
        alu_ref(d_op, d_a, d_b, e_data, e_err, e_zero, e_carry);
      end else if (m_out) begin
        m_age++;
      end
      x0 = 1'b0;
      x1 = 1'b0;
      if (!m_out && m_armed) begin
        if (req0_valid && req1_valid) begin
          x0 = (m_last == 1'b1);
          x1 = (m_last == 1'b0);
        end else begin
          x0 = req0_valid;
          x1 = req1_valid;
        end
      end
      chk1("req0_ready", req0_ready, x0);
      chk1("req1_ready", req1_ready, x1);
      xv = m_out && (m_age >= 1);
      chk1("rsp_valid", rsp_valid, xv);
      if (xv) begin
        chk1("rsp_id", rsp_id, e_id);
        chk64("rsp_data", rsp_data, e_data);
        chk1("rsp_err", rsp_err, e_err);
`ifdef ALU_ARB_FLAGS_EN
        chk1("rsp_zero", rsp_zero, e_zero);
        chk1("rsp_carry", rsp_carry, e_carry);
`endif
      end
      d_acc  = x0 | x1;
      d_port = x1;
      d_op   = x1 ? req1_op : req0_op;
      d_a    = x1 ? req1_a : req0_a;
      d_b    = x1 ? req1_b : req0_b;
      d_hs   = xv && rsp_ready;
      d_rsp  = '{rsp_id, rsp_data, rsp_err, rsp_zero, rsp_carry};
    end
  end

  // Requester drivers: per-port queues, each request held until accepted.
  typedef struct { logic [2:0] op; logic [63:0] a; logic [63:0] b; } req_t;
  req_t q0[$], q1[$];
  req_t cur0 = '{3'd0, 64'd0, 64'd0};
  req_t cur1 = '{3'd0, 64'd0, 64'd0};
  bit   act0, act1, acc0, acc1, hold_rsp;
  int   stall_pct = 0;

  task automatic step();
    @(negedge clk);
    if (act0 && acc0) act0 = 1'b0;
    if (act1 && acc1) act1 = 1'b0;
    if (!act0 && q0.size() > 0) begin cur0 = q0.pop_front(); act0 = 1'b1; end
    if (!act1 && q1.size() > 0) begin cur1 = q1.pop_front(); act1 = 1'b1; end
    req0_valid = act0; req0_op = cur0.op; req0_a = cur0.a; req0_b = cur0.b;
    req1_valid = act1; req1_op = cur1.op; req1_a = cur1.a; req1_b = cur1.b;
    rsp_ready  = !hold_rsp && (int'($urandom_range(99)) >= stall_pct);
    #1;
    acc0 = req0_ready;
    acc1 = req1_ready;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    bit busy;
    do begin
      step();
      #3;
      n++;
      busy = (q0.size() > 0) || (q1.size() > 0) || act0 || act1 || m_out || d_acc;
    end while (busy && n < 200);
    chk1({tag, "_drained"}, busy, 1'b0);
  endtask

  task automatic pop_chk(input string tag, input bit id, input logic [63:0] data,
                         input bit err, input bit z, input bit c);
    rsp_t r;
    if (rsp_log.size() == 0) begin
      chk1({tag, "_present"}, 1'b0, 1'b1);
      return;
    end
    r = rsp_log.pop_front();
    chk1({tag, "_id"}, r.id, id);
    chk64({tag, "_data"}, r.data, data);
    chk1({tag, "_err"}, r.err, err);
`ifdef ALU_ARB_FLAGS_EN
    chk1({tag, "_zero"}, r.zero, z);
    chk1({tag, "_carry"}, r.carry, c);
`endif
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    act0 = 1'b0; act1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    q0.delete(); q1.delete();
    #1;
    chk1("rst_now_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_now_rsp_id", rsp_id, 1'b0);
    chk64("rst_now_rsp_data", rsp_data, 64'd0);
    repeat (cycles) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(3))
      0:       return 64'd0;
      1:       return ONES;
      2:       return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.op = 3'($urandom_range(7));
    r.a  = rnd64();
    r.b  = rnd64();
    return r;
  endfunction

  typedef struct {
    bit port; logic [2:0] op; logic [63:0] a; logic [63:0] b;
    logic [63:0] data; bit err; bit zero; bit carry;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int saved;
    vecs[0]  = '{1'b0, OP_AND, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444,
                 64'h0000_2222_0000_4444, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, OP_OR, ONES, 64'h1111_1111_1111_1111, ONES, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, OP_ADD, ONES, 64'd1, 64'd0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, OP_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd7, 64'd123, 64'd456, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, OP_XOR, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_0000_FFFF_0000,
                 64'hF0F0_0F0F_F0F0_0F0F, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, OP_NOR, 64'd0, 64'd0, ONES, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, OP_SUB, 64'd7, 64'd7, 64'd0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 3'd6, ONES, ONES, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, OP_ADD, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, OP_SUB, 64'd0, 64'd1, ONES, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, OP_AND, 64'h0F, 64'hF0, 64'd0, 1'b0, 1'b1, 1'b0};

    // Reset with both ports requesting: ready must stay low throughout.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 64'd1; req0_b = 64'd1;
    req1_valid = 1'b1; req1_op = OP_OR;  req1_a = 64'd2; req1_b = 64'd2;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1 rst_n = 1'b1;

    // First contention after reset goes to port 0, then grants alternate.
    q0.push_back('{OP_AND, ONES, 64'd1});
    q1.push_back('{OP_OR, ONES, 64'h1111_1111_1111_1111});
    wait_idle("contend");
    pop_chk("contend0", 1'b0, 64'd1, 1'b0, 1'b0, 1'b0);
    pop_chk("contend1", 1'b1, ONES, 1'b0, 1'b0, 1'b0);

    q0.push_back('{OP_ADD, 64'd1, 64'd1});
    q0.push_back('{OP_ADD, 64'd2, 64'd2});
    q1.push_back('{OP_ADD, 64'd3, 64'd3});
    wait_idle("rr");
    pop_chk("rr0", 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
    pop_chk("rr1", 1'b1, 64'd6, 1'b0, 1'b0, 1'b0);
    pop_chk("rr2", 1'b0, 64'd4, 1'b0, 1'b0, 1'b0);

    // Directed operation table, one request at a time.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].port) q1.push_back('{vecs[i].op, vecs[i].a, vecs[i].b});
      else              q0.push_back('{vecs[i].op, vecs[i].a, vecs[i].b});
      wait_idle($sformatf("vec%0d", i));
      pop_chk($sformatf("vec%0d", i), vecs[i].port, vecs[i].data, vecs[i].err,
              vecs[i].zero, vecs[i].carry);
    end

    // Response backpressure for 10 cycles while port 1 waits.
    hold_rsp = 1'b1;
    q0.push_back('{OP_ADD, 64'd10, 64'd20});
    n = 0;
    do begin step(); #3; n++; end while (!(m_out && m_age >= 1) && n < 20);
    chk1("stall_rsp_valid_start", rsp_valid, 1'b1);
    q1.push_back('{OP_OR, 64'hF0, 64'h0F});
    repeat (10) step();
    chk1("stall_rsp_valid_held", rsp_valid, 1'b1);
    chk64("stall_data_held", rsp_data, 64'd30);
    chk1("stall_id_held", rsp_id, 1'b0);
    chk1("stall_req1_ready", req1_ready, 1'b0);
    hold_rsp = 1'b0;
    wait_idle("stall");
    pop_chk("stall0", 1'b0, 64'd30, 1'b0, 1'b0, 1'b0);
    pop_chk("stall1", 1'b1, 64'hFF, 1'b0, 1'b0, 1'b0);

    // Reset during EXEC drops the operation and restores port 0 priority.
    q0.push_back('{OP_ADD, 64'd5, 64'd6});
    n = 0;
    do begin step(); #3; n++; end while (!d_acc && n < 10);
    saved = rsp_log.size();
    do_reset(2);
    wait_idle("post_rst");
    chk64("dropped_no_rsp", 64'(rsp_log.size()), 64'(saved));
    q0.push_back('{OP_XOR, 64'd3, 64'd5});
    q1.push_back('{OP_SUB, 64'd9, 64'd4});
    wait_idle("post_rst_both");
    pop_chk("post_rst0", 1'b0, 64'd6, 1'b0, 1'b0, 1'b0);
    pop_chk("post_rst1", 1'b1, 64'd5, 1'b0, 1'b0, 1'b1);

    // Random traffic with random response stalls, checked by the cycle model.
    stall_pct = 30;
    for (int i = 0; i < 600; i++) begin
      if (q0.size() < 2 && $urandom_range(2) == 0) q0.push_back(rnd_req());
      if (q1.size() < 2 && $urandom_range(2) == 0) q1.push_back(rnd_req());
      step();
    end
    stall_pct = 0;
    wait_idle("random");
    rsp_log.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
